// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC dot-product sequencer.
// Included first by every file in this slice.
package mac_pkg;

    localparam int MAC_OP_W  = 32;
    localparam int MAC_ACC_W = 64;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINAL,
        WAIT_OUT,
        DONE
    } state_e;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Command, operand, MAC and result signals of the dot-product sequencer.
// master = sequencer side, slave = environment (requester + MAC).
interface mac_dot_sequencer_if
    import mac_pkg::*;
#(
    parameter int LEN_W = 16
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_W-1:0]      cmd_len;
    logic                  op_valid;
    logic                  op_ready;
    logic [MAC_OP_W-1:0]   op_a;
    logic [MAC_OP_W-1:0]   op_b;
    logic                  mac_en;
    logic [MAC_OP_W-1:0]   mac_a;
    logic [MAC_OP_W-1:0]   mac_b;
    logic                  mac_finalize;
    logic [MAC_ACC_W-1:0]  mac_out;
    logic                  mac_out_valid;
    logic                  res_valid;
    logic                  res_ready;
    logic [MAC_ACC_W-1:0]  res_data;
    logic                  res_err;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_len,
        input  op_valid, op_a, op_b,
        input  mac_out, mac_out_valid,
        input  res_ready,
        output cmd_ready, op_ready,
        output mac_en, mac_a, mac_b, mac_finalize,
        output res_valid, res_data, res_err, busy
    );

    modport slave (
        output cmd_valid, cmd_len,
        output op_valid, op_a, op_b,
        output mac_out, mac_out_valid,
        output res_ready,
        input  cmd_ready, op_ready,
        input  mac_en, mac_a, mac_b, mac_finalize,
        input  res_valid, res_data, res_err, busy
    );

endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter that saturates at zero and flags it.
// Used for issue spacing, pipeline drain and snapshot timeout.
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Streams a dot-product command into the MAC and returns the delta
// of the accumulator snapshot against the previous snapshot.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int ISSUE_GAP = 1,
    parameter int MULT_LAT  = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_dot_sequencer_if.master  bus_io
);

    // Gap load is two short: op_ready is itself a register stage.
    localparam logic [CNT_W-1:0] GAP_LD =
        CNT_W'(ISSUE_GAP > 1 ? ISSUE_GAP - 2 : 0);
    localparam logic [CNT_W-1:0] DRN_LD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] TMO_LD =
        CNT_W'(TIMEOUT > 2 ? TIMEOUT - 2 : 0);
    localparam bit B2B = (ISSUE_GAP <= 1);

    state_e                state_q;
    logic [LEN_W-1:0]      rem_q;
    logic [MAC_ACC_W-1:0]  base_q;
    logic                  cmd_ready_q;
    logic                  op_ready_q;
    logic                  mac_en_q;
    logic [MAC_OP_W-1:0]   mac_a_q;
    logic [MAC_OP_W-1:0]   mac_b_q;
    logic                  mac_fin_q;
    logic                  res_valid_q;
    logic [MAC_ACC_W-1:0]  res_data_q;
    logic                  res_err_q;
    logic                  busy_q;

    logic hs;
    logic last;
    logic gap_zero;
    logic drn_zero;
    logic tmo_zero;

    assign hs   = (state_q == ISSUE) && op_ready_q
                  && bus_io.op_valid;
    assign last = (rem_q == LEN_W'(1));

    seq_down_counter #(.W(CNT_W)) u_gap (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hs),
        .load_val_i (GAP_LD),
        .dec_i      (1'b1),
        .zero_o     (gap_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_drain (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hs && last),
        .load_val_i (DRN_LD),
        .dec_i      (state_q == DRAIN),
        .zero_o     (drn_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_tmo (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == FINAL),
        .load_val_i (TMO_LD),
        .dec_i      (state_q == WAIT_OUT),
        .zero_o     (tmo_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            base_q      <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_fin_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mac_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus_io.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rem_q       <= bus_io.cmd_len;
                        if (bus_io.cmd_len != '0) begin
                            state_q    <= ISSUE;
                            op_ready_q <= 1'b1;
                        end else begin
                            state_q   <= FINAL;
                            mac_fin_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        mac_en_q   <= 1'b1;
                        mac_a_q    <= bus_io.op_a;
                        mac_b_q    <= bus_io.op_b;
                        rem_q      <= rem_q - 1'b1;
                        op_ready_q <= B2B && !last;
                        if (last) state_q <= DRAIN;
                    end else begin
                        op_ready_q <= gap_zero;
                    end
                end
                DRAIN: begin
                    if (drn_zero) begin
                        state_q   <= FINAL;
                        mac_fin_q <= 1'b1;
                    end
                end
                FINAL: begin
                    mac_fin_q <= 1'b0;
                    state_q   <= WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (bus_io.mac_out_valid) begin
                        res_data_q  <= bus_io.mac_out - base_q;
                        base_q      <= bus_io.mac_out;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (tmo_zero) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus_io.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.cmd_ready    = cmd_ready_q;
    assign bus_io.op_ready     = op_ready_q;
    assign bus_io.mac_en       = mac_en_q;
    assign bus_io.mac_a        = mac_a_q;
    assign bus_io.mac_b        = mac_b_q;
    assign bus_io.mac_finalize = mac_fin_q;
    assign bus_io.res_valid    = res_valid_q;
    assign bus_io.res_data     = res_data_q;
    assign bus_io.res_err      = res_err_q;
    assign bus_io.busy         = busy_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer with a behavioural MAC model.
// Directed vectors; a negedge monitor pops expected results.
module tb_mac_dot_sequencer;

    localparam int LEN_W = 16;
    localparam int GAP   = 3;
    localparam int MLAT  = 4;
    localparam int TMO   = 64;
    localparam int ODLY  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    mac_dot_sequencer_if #(.LEN_W(LEN_W)) bus ();

    mac_dot_sequencer #(
        .LEN_W     (LEN_W),
        .ISSUE_GAP (GAP),
        .MULT_LAT  (MLAT),
        .TIMEOUT   (TMO)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.master)
    );

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Behavioural MAC: product lands in acc MLAT edges after mac_en;
    // snapshot taken at the finalize edge, returned ODLY edges later.
    bit                  mac_silent = 1'b0;
    logic signed [63:0]  acc;
    logic signed [63:0]  snap;
    logic signed [63:0]  pipe [MLAT];
    int                  fcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 0;
            snap <= 0;
            fcnt <= 0;
            for (int i = 0; i < MLAT; i++) pipe[i] <= 0;
            bus.mac_out <= '0;
            bus.mac_out_valid <= 1'b0;
        end else begin
            pipe[0] <= bus.mac_en
                ? longint'($signed(bus.mac_a)) * longint'($signed(bus.mac_b))
                : 64'sd0;
            for (int i = 1; i < MLAT; i++) pipe[i] <= pipe[i-1];
            acc <= acc + pipe[MLAT-1];
            bus.mac_out_valid <= 1'b0;
            if (bus.mac_finalize) begin
                snap <= acc;
                fcnt <= ODLY;
            end else if (fcnt > 0) begin
                fcnt <= fcnt - 1;
                if (fcnt == 1 && !mac_silent) begin
                    bus.mac_out <= snap;
                    bus.mac_out_valid <= 1'b1;
                end
            end
        end
    end

    // Operand source
    logic signed [31:0] qa [$];
    logic signed [31:0] qb [$];
    bit toggle = 1'b0;

    initial begin
        bit hs_pend;
        bit phase;
        phase = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        forever begin
            @(negedge clk);
            hs_pend = bus.op_valid && bus.op_ready;
            @(posedge clk);
            #1;
            if (hs_pend && qa.size() > 0) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            phase = ~phase;
            if (qa.size() > 0 && (!toggle || phase)) begin
                bus.op_valid = 1'b1;
                bus.op_a = qa[0];
                bus.op_b = qb[0];
            end else begin
                bus.op_valid = 1'b0;
            end
        end
    end

    // Scoreboard and monitor
    longint exp_d [$];
    bit     exp_e [$];
    int en_cnt = 0;
    int fin_cnt = 0;
    int last_en = 0;
    int fin_cyc = 0;
    int rise_cyc = 0;
    bit rv_prev = 1'b0;
    bit rr_prev = 1'b1;
    logic [63:0] d_prev = '0;
    logic e_prev = 1'b0;

    always @(negedge clk) begin
        longint ed;
        bit ee;
        if (bus.mac_en) begin
            chk("en_fin_exclusive", longint'(bus.mac_finalize), 0);
            if (en_cnt > 0)
                chk("en_spacing_ge_gap",
                    longint'(cyc - last_en >= GAP), 1);
            last_en = cyc;
            en_cnt++;
        end
        if (bus.mac_finalize) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        if (bus.res_valid && !rv_prev) rise_cyc = cyc;
        if (bus.res_valid && rv_prev && !rr_prev) begin
            chk("hold_data", longint'(bus.res_data), longint'(d_prev));
            chk("hold_err", longint'(bus.res_err), longint'(e_prev));
        end
        if (bus.res_valid && bus.res_ready) begin
            if (exp_d.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got data %0d, required none",
                         longint'(bus.res_data));
            end else begin
                ed = exp_d.pop_front();
                ee = exp_e.pop_front();
                chk("res_data", longint'(bus.res_data), ed);
                chk("res_err", longint'(bus.res_err), longint'(ee));
                if (ee) chk("timeout_latency", rise_cyc - fin_cyc, TMO);
            end
        end
        rv_prev = bus.res_valid;
        rr_prev = bus.res_ready;
        d_prev  = bus.res_data;
        e_prev  = bus.res_err;
    end

    task automatic issue(input int len, input bit push,
                         input longint ed, input bit ee);
        if (push) begin
            exp_d.push_back(ed);
            exp_e.push_back(ee);
        end
        en_cnt = 0;
        fin_cnt = 0;
        bus.cmd_len = LEN_W'(len);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_d.size() == 0 && bus.cmd_ready) done = 1'b1;
        end
        chk("cmd_complete", longint'(done), 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, longint'(bus.cmd_ready), 1);
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_op_ready"}, longint'(bus.op_ready), 0);
        chk({tag, "_mac_en"}, longint'(bus.mac_en), 0);
        chk({tag, "_mac_fin"}, longint'(bus.mac_finalize), 0);
        chk({tag, "_res_valid"}, longint'(bus.res_valid), 0);
        chk({tag, "_res_data"}, longint'(bus.res_data), 0);
        chk({tag, "_res_err"}, longint'(bus.res_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_len = '0;
        bus.res_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic dot product
        qa = '{1, 2, 3, 4};
        qb = '{5, 6, 7, 8};
        issue(4, 1'b1, 70, 1'b0);
        wait_done();
        chk("t1_mac_en_count", en_cnt, 4);
        chk("t1_finalize_count", fin_cnt, 1);

        // 2: back-to-back, result relative to previous snapshot
        qa = '{-3, 2};
        qb = '{7, -5};
        issue(2, 1'b1, -31, 1'b0);
        wait_done();
        chk("t2_mac_en_count", en_cnt, 2);

        // 3: empty vector
        issue(0, 1'b1, 0, 1'b0);
        wait_done();
        chk("t3_mac_en_count", en_cnt, 0);
        chk("t3_finalize_count", fin_cnt, 1);

        // 4: stalling operands, result held while res_ready low
        toggle = 1'b1;
        bus.res_ready = 1'b0;
        qa = '{100, -7, 9};
        qb = '{3, 11, -4};
        issue(3, 1'b1, 187, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.res_valid;
        end
        chk("t4_res_valid_seen", longint'(seen), 1);
        repeat (5) @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        wait_done();
        chk("t4_mac_en_count", en_cnt, 3);
        toggle = 1'b0;

        // 5: snapshot never arrives, then recovery
        mac_silent = 1'b1;
        qa = '{5};
        qb = '{5};
        issue(1, 1'b1, 0, 1'b1);
        wait_done();
        mac_silent = 1'b0;
        qa = '{1, 2};
        qb = '{3, 4};
        issue(2, 1'b1, 36, 1'b0);
        wait_done();

        // 6: reset during issue, then fresh command
        qa = '{1, 1, 1, 1, 1};
        qb = '{2, 2, 2, 2, 2};
        issue(5, 1'b0, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = (en_cnt >= 2);
        end
        chk("t6_two_issued", longint'(seen), 1);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk_reset_outs("t6_midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        qa = '{-2};
        qb = '{3};
        issue(1, 1'b1, -6, 1'b0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
